ysyx_22040759_mem_stage: RTL and testbench



---
 rtl/ysyx_22040759_mem_stage_pkg.sv | 27 ++
 rtl/ysyx_22040759_lsu_align.sv | 51 +++++
 rtl/ysyx_22040759_mem_stage.sv | 147 ++++++++++++++
 tb/tb_ysyx_22040759_mem_stage.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040759_mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, func3 / write-back codes
// and the data-port FSM encoding.
package ysyx_22040759_mem_stage_pkg;

  localparam int MS_ES_BUS_W = 173;
  localparam int MS_WS_BUS_W = 166;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } ms_state_e;

endpackage

// File: rtl/ysyx_22040759_lsu_align.sv
// Byte-lane alignment for the data port: store shift/strobes and
// load shift with sign/zero extension.
module ysyx_22040759_lsu_align
  import ysyx_22040759_mem_stage_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [2:0]  off,
  input  logic [63:0] store_src,
  input  logic [63:0] rdata,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic [63:0] load_data
);

  logic [5:0]  sh_amt;
  logic [63:0] rshift;

  assign sh_amt = {off, 3'b000};
  assign rshift = rdata >> sh_amt;

  // Lanes shifted past byte 7 fall off; 8-byte-crossing accesses never occur.
  always_comb begin
    wdata = store_src << sh_amt;
    wstrb = 8'h00;
    case (func3)
      F3_B: begin
        wdata = {8{store_src[7:0]}};
        wstrb = 8'h01 << off;
      end
      F3_H:    wstrb = 8'h03 << off;
      F3_W:    wstrb = 8'h0F << off;
      F3_D:    wstrb = 8'hFF;
      default: wstrb = 8'h00;
    endcase
  end

  always_comb begin
    load_data = rshift;
    case (func3)
      F3_B:    load_data = {{56{rshift[7]}}, rshift[7:0]};
      F3_H:    load_data = {{48{rshift[15]}}, rshift[15:0]};
      F3_W:    load_data = {{32{rshift[31]}}, rshift[31:0]};
      F3_D:    load_data = rshift;
      F3_BU:   load_data = {56'd0, rshift[7:0]};
      F3_HU:   load_data = {48'd0, rshift[15:0]};
      F3_WU:   load_data = {32'd0, rshift[31:0]};
      default: load_data = rshift;
    endcase
  end

endmodule

// File: rtl/ysyx_22040759_mem_stage.sv
// MEM pipeline stage: latches the EXE payload, runs one data-port transaction
// per load/store and forwards the write-back bundle to WB.
module ysyx_22040759_mem_stage
  import ysyx_22040759_mem_stage_pkg::*;
#(
  parameter int BUS_W    = MS_ES_BUS_W,
  parameter int WS_BUS_W = MS_WS_BUS_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                es_to_ms_valid,
  input  logic [BUS_W-1:0]    es_to_ms_bus,
  input  logic [63:0]         es_alu_result,
  output logic                ms_allowin,
  input  logic                ws_allowin,
  output logic                ms_to_ws_valid,
  output logic [WS_BUS_W-1:0] ms_to_ws_bus,
  output logic [63:0]         ms_alu_result,
  output logic [4:0]          ms_rd,
  output logic                ms_reg_wen,
  output logic                ms_is_load,
  output logic                dreq_valid,
  input  logic                dreq_ready,
  output logic                dreq_wen,
  output logic [63:0]         dreq_addr,
  output logic [63:0]         dreq_wdata,
  output logic [7:0]          dreq_wstrb,
  input  logic                drsp_valid,
  input  logic [63:0]         drsp_rdata
);

  logic             ms_valid;
  logic             ms_ready_go;
  logic [BUS_W-1:0] bus_r;
  logic [63:0]      alu_r;
  logic [63:0]      rdata_r;
  ms_state_e        state;

  logic [31:0] inst;
  logic [63:0] store_src;
  logic        mem_wen;
  logic        mem_ren;
  logic [2:0]  func3;
  logic [1:0]  wreg_sel;
  logic        reg_wen;
  logic [4:0]  rd;
  logic [63:0] pc;
  logic [63:0] load_data;
  logic [63:0] result;
  logic        capture;
  logic        es_mem_op;

  assign inst      = bus_r[172:141];
  assign store_src = bus_r[140:77];
  assign mem_wen   = bus_r[76];
  assign mem_ren   = bus_r[75];
  assign func3     = bus_r[74:72];
  assign wreg_sel  = bus_r[71:70];
  assign reg_wen   = bus_r[69];
  assign rd        = bus_r[68:64];
  assign pc        = bus_r[63:0];

  assign ms_ready_go    = !(mem_wen || mem_ren) || (state == DONE);
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign capture        = es_to_ms_valid && ms_allowin;
  assign es_mem_op      = es_to_ms_bus[76] || es_to_ms_bus[75];

  always_ff @(posedge clk) begin
    if (rst) begin
      ms_valid <= 1'b0;
      bus_r    <= '0;
      alu_r    <= '0;
    end else begin
      if (ms_allowin) ms_valid <= es_to_ms_valid;
      if (capture) begin
        bus_r <= es_to_ms_bus;
        alu_r <= es_alu_result;
      end
    end
  end

  // A new memory op captured as DONE retires goes straight to REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dreq_valid <= 1'b0;
      rdata_r    <= '0;
    end else begin
      case (state)
        IDLE: if (capture && es_mem_op) begin
          state      <= REQ;
          dreq_valid <= 1'b1;
        end
        REQ: if (dreq_ready) begin
          state      <= WAIT;
          dreq_valid <= 1'b0;
        end
        WAIT: if (drsp_valid) begin
          state   <= DONE;
          rdata_r <= drsp_rdata;
        end
        DONE: if (ws_allowin) begin
          if (capture && es_mem_op) begin
            state      <= REQ;
            dreq_valid <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          dreq_valid <= 1'b0;
        end
      endcase
    end
  end

  ysyx_22040759_lsu_align u_align (
    .func3     (func3),
    .off       (alu_r[2:0]),
    .store_src (store_src),
    .rdata     (rdata_r),
    .wdata     (dreq_wdata),
    .wstrb     (dreq_wstrb),
    .load_data (load_data)
  );

  always_comb begin
    result = 64'd0;
    case (wreg_sel)
      WB_ALU:  result = alu_r;
      WB_MEM:  result = load_data;
      WB_PC4:  result = pc + 64'd4;
      default: result = 64'd0;
    endcase
  end

  assign dreq_wen      = mem_wen;
  assign dreq_addr     = {alu_r[63:3], 3'b000};
  assign ms_to_ws_bus  = {inst, reg_wen, rd, result, pc};
  assign ms_alu_result = alu_r;
  assign ms_rd         = rd;
  assign ms_reg_wen    = reg_wen && ms_valid;
  assign ms_is_load    = mem_ren && ms_valid;

endmodule

// File: tb/tb_ysyx_22040759_mem_stage.sv
// Scoreboard bench for the MEM stage: stimulus pushes expected WB bundles and
// data requests; negedge monitors pop and compare them.
module tb_ysyx_22040759_mem_stage;

  typedef struct {
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    bit          chk_data;
  } req_t;

  logic         clk;
  logic         rst;
  logic         es_to_ms_valid;
  logic [172:0] es_to_ms_bus;
  logic [63:0]  es_alu_result;
  logic         ms_allowin;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [165:0] ms_to_ws_bus;
  logic [63:0]  ms_alu_result;
  logic [4:0]   ms_rd;
  logic         ms_reg_wen;
  logic         ms_is_load;
  logic         dreq_valid;
  logic         dreq_ready;
  logic         dreq_wen;
  logic [63:0]  dreq_addr;
  logic [63:0]  dreq_wdata;
  logic [7:0]   dreq_wstrb;
  logic         drsp_valid;
  logic [63:0]  drsp_rdata;

  int errors = 0;
  int checks = 0;
  int req_count = 0;
  int base_cnt;

  logic [165:0] res_q[$];
  req_t         req_q[$];
  logic [165:0] mon_bus;
  req_t         mon_req;

  ysyx_22040759_mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .es_to_ms_valid (es_to_ms_valid),
    .es_to_ms_bus   (es_to_ms_bus),
    .es_alu_result  (es_alu_result),
    .ms_allowin     (ms_allowin),
    .ws_allowin     (ws_allowin),
    .ms_to_ws_valid (ms_to_ws_valid),
    .ms_to_ws_bus   (ms_to_ws_bus),
    .ms_alu_result  (ms_alu_result),
    .ms_rd          (ms_rd),
    .ms_reg_wen     (ms_reg_wen),
    .ms_is_load     (ms_is_load),
    .dreq_valid     (dreq_valid),
    .dreq_ready     (dreq_ready),
    .dreq_wen       (dreq_wen),
    .dreq_addr      (dreq_addr),
    .dreq_wdata     (dreq_wdata),
    .dreq_wstrb     (dreq_wstrb),
    .drsp_valid     (drsp_valid),
    .drsp_rdata     (drsp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with nothing expected", name);
  endtask

  always @(negedge clk) begin
    if (!rst && ms_to_ws_valid && ws_allowin) begin
      if (res_q.size() == 0) fail_now("unexpected_wb");
      else begin
        mon_bus = res_q.pop_front();
        check("wb_bus", ms_to_ws_bus, mon_bus);
      end
    end
    if (!rst && dreq_valid && dreq_ready) begin
      req_count++;
      if (req_q.size() == 0) fail_now("unexpected_req");
      else begin
        mon_req = req_q.pop_front();
        check("req_wen_addr", {dreq_wen, dreq_addr}, {mon_req.wen, mon_req.addr});
        if (mon_req.chk_data)
          check("req_wdata_strb", {dreq_wdata, dreq_wstrb}, {mon_req.wdata, mon_req.strb});
      end
    end
  end

  function automatic logic [172:0] mk_bus(input logic [31:0] inst, input logic [63:0] src,
      input logic wen, input logic ren, input logic [2:0] f3, input logic [1:0] sel,
      input logic rwen, input logic [4:0] rd, input logic [63:0] pc);
    return {inst, src, wen, ren, f3, sel, rwen, rd, pc};
  endfunction

  task automatic send(input logic [172:0] bus, input logic [63:0] alu);
    int n;
    n = 0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = bus;
    es_alu_result  = alu;
    while (!ms_allowin && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ms_allowin) check("send_timeout", ms_allowin, 1'b1);
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0;
  endtask

  task automatic serve(input int rdly, input logic [63:0] rdata);
    int n;
    n = 0;
    check("req_after_capture", dreq_valid, 1'b1);
    while (!dreq_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i <= rdly; i++) begin
      if (req_q.size() != 0) begin
        check("req_stable_hdr", {dreq_valid, dreq_wen, dreq_addr}, {1'b1, req_q[0].wen, req_q[0].addr});
        if (req_q[0].chk_data)
          check("req_stable_data", {dreq_wdata, dreq_wstrb}, {req_q[0].wdata, req_q[0].strb});
      end
      if (i < rdly) begin
        @(posedge clk); #1;
      end
    end
    dreq_ready = 1'b1;
    @(posedge clk); #1;
    dreq_ready = 1'b0;
    check("req_dropped", dreq_valid, 1'b0);
    drsp_valid = 1'b1;
    drsp_rdata = rdata;
    @(posedge clk); #1;
    drsp_valid = 1'b0;
  endtask

  task automatic do_op(input logic [31:0] inst, input logic [63:0] src, input logic wen,
      input logic ren, input logic [2:0] f3, input logic [1:0] sel, input logic rwen,
      input logic [4:0] rd, input logic [63:0] pc, input logic [63:0] alu,
      input logic [63:0] exp_res, input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
      input logic [7:0] exp_strb, input int rdly, input logic [63:0] rdata);
    req_t r;
    res_q.push_back({inst, rwen, rd, exp_res, pc});
    if (wen || ren) begin
      r.wen = wen; r.addr = exp_addr; r.wdata = exp_wdata; r.strb = exp_strb; r.chk_data = wen;
      req_q.push_back(r);
    end
    send(mk_bus(inst, src, wen, ren, f3, sel, rwen, rd, pc), alu);
    if (wen || ren) serve(rdly, rdata);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((res_q.size() != 0 || req_q.size() != 0) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", res_q.size() + req_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r;
    rst = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0; es_alu_result = '0;
    ws_allowin = 1'b1; dreq_ready = 1'b0; drsp_valid = 1'b0; drsp_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_outputs", {ms_to_ws_valid, dreq_valid, ms_reg_wen, ms_is_load, ms_allowin}, 5'b00001);
    check("rst_payload", {ms_alu_result, ms_rd}, 69'd0);

    // ALU op: result visible the cycle after capture, no data request
    base_cnt = req_count;
    do_op(32'h0000_0013, 64'd0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b1, 5'd5, 64'h100, 64'h1234,
          64'h1234, 64'd0, 64'd0, 8'd0, 0, 64'd0);
    check("alu_wb_valid", {ms_to_ws_valid, ms_reg_wen, ms_rd, ms_alu_result}, {1'b1, 1'b1, 5'd5, 64'h1234});
    drain();
    check("alu_no_req", req_count - base_cnt, 0);

    do_op(32'h0030_0083, 64'd0, 1'b0, 1'b1, 3'b000, 2'b01, 1'b1, 5'd6, 64'h104, 64'h1003,
          64'hFFFF_FFFF_FFFF_FF80, 64'h1000, 64'd0, 8'd0, 0, 64'h0000_0000_8000_0000);
    drain();
    do_op(32'h0030_4083, 64'd0, 1'b0, 1'b1, 3'b100, 2'b01, 1'b1, 5'd7, 64'h108, 64'h1003,
          64'h80, 64'h1000, 64'd0, 8'd0, 0, 64'h0000_0000_8000_0000);
    drain();
    do_op(32'h0020_1083, 64'd0, 1'b0, 1'b1, 3'b001, 2'b01, 1'b1, 5'd8, 64'h10C, 64'h6002,
          64'hFFFF_FFFF_FFFF_F00D, 64'h6000, 64'd0, 8'd0, 1, 64'h0000_0000_F00D_0000);
    drain();
    do_op(32'h0020_5083, 64'd0, 1'b0, 1'b1, 3'b101, 2'b01, 1'b1, 5'd9, 64'h110, 64'h6002,
          64'h0000_0000_0000_F00D, 64'h6000, 64'd0, 8'd0, 0, 64'h0000_0000_F00D_0000);
    drain();

    // SH with a 3-cycle ready stall: exactly one request
    base_cnt = req_count;
    do_op(32'h0000_1023, 64'hBEEF, 1'b1, 1'b0, 3'b001, 2'b00, 1'b0, 5'd0, 64'h114, 64'h2006,
          64'h2006, 64'h2000, 64'hBEEF_0000_0000_0000, 8'hC0, 3, 64'd0);
    drain();
    check("sh_one_req", req_count - base_cnt, 1);
    do_op(32'h0000_0023, 64'hAB, 1'b1, 1'b0, 3'b000, 2'b00, 1'b0, 5'd0, 64'h118, 64'h7005,
          64'h7005, 64'h7000, 64'hABAB_ABAB_ABAB_ABAB, 8'h20, 0, 64'd0);
    drain();
    do_op(32'h0000_2023, 64'h1122_3344, 1'b1, 1'b0, 3'b010, 2'b00, 1'b0, 5'd0, 64'h11C, 64'h7004,
          64'h7004, 64'h7000, 64'h1122_3344_0000_0000, 8'hF0, 1, 64'd0);
    drain();

    // LW with WB stalled: DONE holds, no re-issue, delivered once
    ws_allowin = 1'b0;
    base_cnt = req_count;
    do_op(32'h0000_2083, 64'd0, 1'b0, 1'b1, 3'b010, 2'b01, 1'b1, 5'd10, 64'h120, 64'h3004,
          64'hFFFF_FFFF_8765_4321, 64'h3000, 64'd0, 8'd0, 0, 64'h8765_4321_0000_0000);
    for (int i = 0; i < 4; i++) begin
      check("lw_hold", {ms_to_ws_valid, ms_allowin, dreq_valid, ms_is_load}, 4'b1001);
      @(posedge clk); #1;
    end
    check("lw_no_reissue", req_count - base_cnt, 1);
    ws_allowin = 1'b1;
    @(posedge clk); #1;
    check("lw_once", {ms_to_ws_valid, res_q.size()}, 33'd0);

    // Non-memory op with WB stalled
    ws_allowin = 1'b0;
    do_op(32'h0000_0033, 64'd0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b1, 5'd11, 64'h124, 64'h9999,
          64'h9999, 64'd0, 64'd0, 8'd0, 0, 64'd0);
    repeat (2) begin
      check("alu_hold", {ms_to_ws_valid, ms_allowin}, 2'b10);
      @(posedge clk); #1;
    end
    ws_allowin = 1'b1;
    drain();

    // LD then SD back to back: the SD is captured as the LD retires
    do_op(32'h0000_3083, 64'd0, 1'b0, 1'b1, 3'b011, 2'b01, 1'b1, 5'd12, 64'h128, 64'h5000,
          64'hDEAD_BEEF_CAFE_F00D, 64'h5000, 64'd0, 8'd0, 0, 64'hDEAD_BEEF_CAFE_F00D);
    do_op(32'h0000_3023, 64'h1122_3344_5566_7788, 1'b1, 1'b0, 3'b011, 2'b00, 1'b0, 5'd0, 64'h12C,
          64'h4000, 64'h4000, 64'h4000, 64'h1122_3344_5566_7788, 8'hFF, 0, 64'd0);
    drain();

    do_op(32'h0000_006F, 64'd0, 1'b0, 1'b0, 3'b000, 2'b10, 1'b1, 5'd1, 64'h8000_0000, 64'h55,
          64'h8000_0004, 64'd0, 64'd0, 8'd0, 0, 64'd0);
    drain();

    // Reset while waiting for the response: op discarded, late response ignored
    r.wen = 1'b0; r.addr = 64'h8000; r.wdata = 64'd0; r.strb = 8'd0; r.chk_data = 1'b0;
    req_q.push_back(r);
    send(mk_bus(32'h0000_3083, 64'd0, 1'b0, 1'b1, 3'b011, 2'b01, 1'b1, 5'd13, 64'h130), 64'h8000);
    dreq_ready = 1'b1;
    @(posedge clk); #1;
    dreq_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_wait", {ms_to_ws_valid, dreq_valid, ms_is_load, ms_allowin}, 4'b0001);
    drsp_valid = 1'b1;
    drsp_rdata = 64'h1234_5678_9ABC_DEF0;
    @(posedge clk); #1;
    drsp_valid = 1'b0;
    repeat (3) begin
      check("rst_ignore_rsp", {ms_to_ws_valid, dreq_valid}, 2'b00);
      @(posedge clk); #1;
    end

    do_op(32'h0000_0013, 64'd0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b1, 5'd14, 64'h200, 64'hABCD,
          64'hABCD, 64'd0, 64'd0, 8'd0, 0, 64'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
